serial_deser_ctrl: RTL and testbench

Frame-level controller that sequences a right-shift register to deserialize an LSB-first serial stream into DEPTH-bit words. It gates the shift enable, counts bits and aligns frames on a sync marker. Each completed word is captured into a holding register and presented on a valid/ready output port. It sits between a serial receive front end and any parallel word consumer.

---
 rtl/serial_deser_ctrl_pkg.sv | 14 +
 rtl/serial_deser_ctrl_if.sv | 22 ++
 rtl/right_shift_register_base.sv | 22 ++
 rtl/serial_deser_ctrl.sv | 167 ++++++++++++++++
 tb/tb_serial_deser_ctrl.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_deser_ctrl_pkg.sv
// Shared types for the serial deserializer: FSM state encoding and bit-count width helper.
package serial_deser_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StShift  = 2'd1,
        StParity = 2'd2
    } state_e;

    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/serial_deser_ctrl_if.sv
// Serial input and parallel word output bundle of the deserializer.
interface serial_deser_ctrl_if #(
    parameter int unsigned DEPTH = 8
);
    logic             ser_valid;
    logic             ser_in;
    logic             ser_sync;
    logic [DEPTH-1:0] frame_data;
    logic             frame_valid;
    logic             frame_ready;
    logic             frame_par_err;

    modport master (
        output ser_valid, ser_in, ser_sync, frame_ready,
        input  frame_data, frame_valid, frame_par_err
    );

    modport slave (
        input  ser_valid, ser_in, ser_sync, frame_ready,
        output frame_data, frame_valid, frame_par_err
    );
endinterface

// File: rtl/right_shift_register_base.sv
// Enable-gated right-shift register: new bits enter at the MSB and move toward bit 0.
module right_shift_register_base #(
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             in,
    output logic [DEPTH-1:0] out
);
    logic [DEPTH-1:0] sr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sr_q <= '0;
        end else if (enable) begin
            sr_q <= {in, sr_q[DEPTH-1:1]};
        end
    end

    assign out = sr_q;
endmodule

// File: rtl/serial_deser_ctrl.sv
// Frame controller deserializing an LSB-first serial stream into DEPTH-bit words.
// Optional even-parity bit per frame when DESER_PARITY_EN is defined.
module serial_deser_ctrl
    import serial_deser_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    serial_deser_ctrl_if.slave   bus,
    output logic                 busy,
    output logic                 overflow,
    output logic                 sync_err
);
    localparam int unsigned CntW = cnt_width(DEPTH);

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             last_bit;
    logic             shift_en, frame_done, resync;
    logic [DEPTH-1:0] sr_out, cap_data;
    logic [DEPTH-1:0] data_q;
    logic             valid_q, ovf_q, serr_q;
`ifdef DESER_PARITY_EN
    logic             cap_par, par_q;
`endif

    right_shift_register_base #(
        .DEPTH(DEPTH)
    ) u_sr (
        .clk   (clk),
        .reset (reset),
        .enable(shift_en),
        .in    (bus.ser_in),
        .out   (sr_out)
    );

    assign last_bit = (cnt_q == CntW'(DEPTH - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (bus.ser_valid) begin
            case (state_q)
                StIdle: begin
                    if (bus.ser_sync) begin
                        state_d = StShift;
                        cnt_d   = CntW'(1);
                    end
                end
                StShift: begin
                    if (bus.ser_sync) begin
                        cnt_d = CntW'(1);
                    end else if (last_bit) begin
`ifdef DESER_PARITY_EN
                        state_d = StParity;
                        cnt_d   = CntW'(DEPTH);
`else
                        state_d = StIdle;
                        cnt_d   = '0;
`endif
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
`ifdef DESER_PARITY_EN
                StParity: begin
                    if (bus.ser_sync) begin
                        state_d = StShift;
                        cnt_d   = CntW'(1);
                    end else begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end
                end
`endif
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // A resync shifts its bit in as bit 0; stale bits fall out before the next capture.
    always_comb begin
        shift_en   = 1'b0;
        frame_done = 1'b0;
        resync     = 1'b0;
        cap_data   = DEPTH'({bus.ser_in, sr_out} >> 1);
`ifdef DESER_PARITY_EN
        cap_par    = 1'b0;
`endif
        if (bus.ser_valid) begin
            case (state_q)
                StIdle: shift_en = bus.ser_sync;
                StShift: begin
                    shift_en = 1'b1;
                    resync   = bus.ser_sync;
`ifndef DESER_PARITY_EN
                    frame_done = !bus.ser_sync && last_bit;
`endif
                end
`ifdef DESER_PARITY_EN
                StParity: begin
                    shift_en   = bus.ser_sync;
                    resync     = bus.ser_sync;
                    frame_done = !bus.ser_sync;
                    cap_data   = sr_out;
                    cap_par    = ^{sr_out, bus.ser_in};
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            serr_q  <= 1'b0;
`ifdef DESER_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            if (resync) begin
                serr_q <= 1'b1;
            end
            if (frame_done) begin
                if (!valid_q || bus.frame_ready) begin
                    data_q  <= cap_data;
                    valid_q <= 1'b1;
`ifdef DESER_PARITY_EN
                    par_q   <= cap_par;
`endif
                end else begin
                    ovf_q <= 1'b1;
                end
            end else if (valid_q && bus.frame_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.frame_data  = data_q;
    assign bus.frame_valid = valid_q;
`ifdef DESER_PARITY_EN
    assign bus.frame_par_err = par_q;
`else
    assign bus.frame_par_err = 1'b0;
`endif
    assign busy     = (state_q != StIdle);
    assign overflow = ovf_q;
    assign sync_err = serr_q;
endmodule

// File: tb/tb_serial_deser_ctrl.sv
// Directed self-checking bench for serial_deser_ctrl (DEPTH=8); honours DESER_PARITY_EN.
module tb_serial_deser_ctrl;
    localparam int unsigned DEPTH = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic busy, overflow, sync_err;
    int   n_tests = 0;
    int   n_fail = 0;
    logic [7:0] got[$];

    serial_deser_ctrl_if #(.DEPTH(DEPTH)) bus ();

    serial_deser_ctrl #(
        .DEPTH(DEPTH)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .busy    (busy),
        .overflow(overflow),
        .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    // Records every word accepted by the consumer.
    always @(posedge clk) begin
        if (!reset && bus.frame_valid && bus.frame_ready) got.push_back(bus.frame_data);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: sim time expired, got %0d required finish", $time);
        $fatal(1, "timeout");
    end

    task automatic drive(input logic v, input logic s, input logic d);
        @(negedge clk);
        bus.ser_valid = v;
        bus.ser_sync  = s;
        bus.ser_in    = d;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic send_data(input logic [7:0] w, input bit gaps);
        for (int i = 0; i < 8; i++) begin
            if (gaps && i > 0) repeat ($urandom_range(0, 2)) drive(1'b0, 1'b0, 1'b0);
            drive(1'b1, i == 0, w[i]);
        end
    endtask

    task automatic send_frame(input logic [7:0] w, input bit gaps);
        send_data(w, gaps);
`ifdef DESER_PARITY_EN
        if (gaps) repeat ($urandom_range(0, 2)) drive(1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, ^w);
`endif
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.ser_valid = 1'b0;
        bus.ser_sync = 1'b0;
        bus.ser_in = 1'b0;
        bus.frame_ready = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if (bus.frame_valid !== 1'b0 || bus.frame_data !== 8'h00 || bus.frame_par_err !== 1'b0) begin
            $display("FAIL reset_frame: got v=%b d=%h p=%b required 0/00/0",
                     bus.frame_valid, bus.frame_data, bus.frame_par_err);
            n_fail++;
        end
        n_tests++;
        if (busy !== 1'b0 || overflow !== 1'b0 || sync_err !== 1'b0) begin
            $display("FAIL reset_flags: got busy=%b ovf=%b serr=%b required 0/0/0",
                     busy, overflow, sync_err);
            n_fail++;
        end
        reset = 1'b0;
    endtask

    task automatic test_single();
        got.delete();
        bus.frame_ready = 1'b1;
        send_frame(8'b0110_1011, 1'b0);
        idle(1);
        n_tests++;
        if (bus.frame_valid !== 1'b1 || bus.frame_data !== 8'h6B) begin
            $display("FAIL single_word: got v=%b d=%h required 1/6b", bus.frame_valid, bus.frame_data);
            n_fail++;
        end
        n_tests++;
        if (bus.frame_par_err !== 1'b0) begin
            $display("FAIL single_par: got %b required 0", bus.frame_par_err);
            n_fail++;
        end
        idle(1);
        n_tests++;
        if (bus.frame_valid !== 1'b0 || busy !== 1'b0 || got.size() != 1) begin
            $display("FAIL single_after: got v=%b busy=%b n=%0d required 0/0/1",
                     bus.frame_valid, busy, got.size());
            n_fail++;
        end
    endtask

    task automatic test_back_to_back();
        got.delete();
        bus.frame_ready = 1'b1;
        send_frame(8'hA5, 1'b1);
        send_frame(8'h3C, 1'b1);
        idle(3);
        n_tests++;
        if (got.size() != 2) begin
            $display("FAIL b2b_count: got %0d required 2", got.size());
            n_fail++;
        end else begin
            n_tests++;
            if (got[0] !== 8'hA5 || got[1] !== 8'h3C) begin
                $display("FAIL b2b_words: got %h,%h required a5,3c", got[0], got[1]);
                n_fail++;
            end
        end
        n_tests++;
        if (overflow !== 1'b0) begin
            $display("FAIL b2b_overflow: got %b required 0", overflow);
            n_fail++;
        end
    endtask

    task automatic test_backpressure();
        got.delete();
        bus.frame_ready = 1'b0;
        send_frame(8'h01, 1'b0);
        idle(2);
        n_tests++;
        if (bus.frame_valid !== 1'b1 || bus.frame_data !== 8'h01 || overflow !== 1'b0) begin
            $display("FAIL bp_first: got v=%b d=%h ovf=%b required 1/01/0",
                     bus.frame_valid, bus.frame_data, overflow);
            n_fail++;
        end
        send_frame(8'hFF, 1'b0);
        idle(2);
        n_tests++;
        if (bus.frame_valid !== 1'b1 || bus.frame_data !== 8'h01 || overflow !== 1'b1) begin
            $display("FAIL bp_held: got v=%b d=%h ovf=%b required 1/01/1",
                     bus.frame_valid, bus.frame_data, overflow);
            n_fail++;
        end
        bus.frame_ready = 1'b1;
        idle(1);
        n_tests++;
        if (bus.frame_valid !== 1'b0 || got.size() != 1 || got[0] !== 8'h01) begin
            $display("FAIL bp_release: got v=%b n=%0d w=%h required 0/1/01",
                     bus.frame_valid, got.size(), (got.size() > 0) ? got[0] : 8'hxx);
            n_fail++;
        end
    endtask

    task automatic test_resync();
        got.delete();
        n_tests++;
        if (sync_err !== 1'b0) begin
            $display("FAIL resync_pre: got %b required 0", sync_err);
            n_fail++;
        end
        drive(1'b1, 1'b1, 1'b1);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b0);
        send_frame(8'h96, 1'b0);
        idle(3);
        n_tests++;
        if (sync_err !== 1'b1 || busy !== 1'b0) begin
            $display("FAIL resync_flag: got serr=%b busy=%b required 1/0", sync_err, busy);
            n_fail++;
        end
        n_tests++;
        if (got.size() != 1 || got[0] !== 8'h96) begin
            $display("FAIL resync_word: got n=%0d w=%h required 1/96",
                     got.size(), (got.size() > 0) ? got[0] : 8'hxx);
            n_fail++;
        end
    endtask

    task automatic test_reset_mid_frame();
        got.delete();
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b1);
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b1) begin
            $display("FAIL rst_busy_pre: got %b required 1", busy);
            n_fail++;
        end
        reset = 1'b1;
        bus.ser_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || overflow !== 1'b0 || sync_err !== 1'b0 ||
            bus.frame_valid !== 1'b0 || bus.frame_data !== 8'h00 || bus.frame_par_err !== 1'b0) begin
            $display("FAIL rst_mid: got busy=%b ovf=%b serr=%b v=%b d=%h p=%b required all 0",
                     busy, overflow, sync_err, bus.frame_valid, bus.frame_data, bus.frame_par_err);
            n_fail++;
        end
        reset = 1'b0;
        send_frame(8'h5A, 1'b0);
        idle(3);
        n_tests++;
        if (got.size() != 1 || got[0] !== 8'h5A) begin
            $display("FAIL rst_recover: got n=%0d w=%h required 1/5a",
                     got.size(), (got.size() > 0) ? got[0] : 8'hxx);
            n_fail++;
        end
    endtask

    task automatic test_parity();
        bus.frame_ready = 1'b1;
`ifdef DESER_PARITY_EN
        send_data(8'h03, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        idle(1);
        n_tests++;
        if (bus.frame_valid !== 1'b1 || bus.frame_data !== 8'h03 || bus.frame_par_err !== 1'b0) begin
            $display("FAIL par_ok: got v=%b d=%h p=%b required 1/03/0",
                     bus.frame_valid, bus.frame_data, bus.frame_par_err);
            n_fail++;
        end
        idle(1);
        send_data(8'h07, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        idle(1);
        n_tests++;
        if (bus.frame_valid !== 1'b1 || bus.frame_data !== 8'h07 || bus.frame_par_err !== 1'b1) begin
            $display("FAIL par_bad: got v=%b d=%h p=%b required 1/07/1",
                     bus.frame_valid, bus.frame_data, bus.frame_par_err);
            n_fail++;
        end
        idle(2);
`else
        send_data(8'h07, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        n_tests++;
        if (bus.frame_valid !== 1'b1 || bus.frame_data !== 8'h07 || bus.frame_par_err !== 1'b0) begin
            $display("FAIL nopar_word: got v=%b d=%h p=%b required 1/07/0",
                     bus.frame_valid, bus.frame_data, bus.frame_par_err);
            n_fail++;
        end
        idle(1);
        n_tests++;
        if (busy !== 1'b0 || bus.frame_valid !== 1'b0) begin
            $display("FAIL nopar_ninth: got busy=%b v=%b required 0/0", busy, bus.frame_valid);
            n_fail++;
        end
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_resync();
        test_reset_mid_frame();
        test_parity();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
